// File: rtl/calc_btn_pkg.sv
// rtl/calc_btn_pkg.sv - shared types and defaults for the push-button conditioner
package calc_btn_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_e;

  localparam int DEFAULT_STABLE_CYCLES = 50000;
  localparam int DEFAULT_CNT_W         = 16;

  // The counter only ever holds 0..stable-1, so clog2(stable) bits suffice.
  function automatic int calc_cnt_w(input int stable);
    return (stable <= 2) ? 1 : $clog2(stable);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: two-flop synchroniser, stability counter and level FSM
module debounce_channel
  import calc_btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  generate
    if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("debounce_channel: STABLE_CYCLES must be at least 1");
    end
    if ((64'd1 << CNT_W) < 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
      $error("debounce_channel: CNT_W too narrow for STABLE_CYCLES");
    end
  endgenerate

  logic             r_sync1;
  logic             r_sync2;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_s;

  // Normalised sample: 1 means pressed regardless of pin polarity.
  assign w_s   = r_sync2 ^ ACTIVE_LOW;
  assign level = r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      case (r_state)
        RELEASED: begin
          if (w_s) begin
            if (STABLE_CYCLES == 1) begin
              r_state <= PRESSED;
              r_level <= 1'b1;
            end else begin
              r_state <= ARM_PRESS;
              r_cnt   <= CNT_ONE;
            end
          end
        end
        ARM_PRESS: begin
          // A single released sample throws away all accumulated credit.
          if (!w_s) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_s) begin
            if (STABLE_CYCLES == 1) begin
              r_state <= RELEASED;
              r_level <= 1'b0;
            end else begin
              r_state <= ARM_RELEASE;
              r_cnt   <= CNT_ONE;
            end
          end
        end
        ARM_RELEASE: begin
          if (w_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - N independent debounced button channels plus an any-pressed flag
module button_debounce
  import calc_btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             btn_any
);

  logic [N_BTN-1:0] w_level;

  generate
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W),
        .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_raw[g]),
        .level(w_level[g])
      );
    end
  endgenerate

  assign btn_level = w_level;
  assign btn_any   = |w_level;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed bench for button_debounce with STABLE_CYCLES=4
module tb_button_debounce;
  import calc_btn_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic       btn_any;

  int tests_run;
  int tests_failed;

  button_debounce #(
    .N_BTN        (4),
    .STABLE_CYCLES(4),
    .CNT_W        (calc_cnt_w(4)),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_any  (btn_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn_raw = 4'b1111;
    step(2);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (btn_level !== 4'b0000 || btn_any !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: level=%b any=%b expected 0000/0", btn_level, btn_any);
    end
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      tests_run++;
      if (btn_level !== 4'b0000 || btn_any !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold cyc %0d: level=%b any=%b expected 0000/0", i, btn_level, btn_any);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_raw[0] = 1'b0;
    step(5);
    tests_run++;
    if (btn_level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL press_early: level=%b expected 0000", btn_level);
    end
    step(1);
    tests_run++;
    if (btn_level !== 4'b0001 || btn_any !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_rise: level=%b any=%b expected 0001/1", btn_level, btn_any);
    end
    step(3);
    btn_raw[0] = 1'b1;
    step(5);
    tests_run++;
    if (btn_level !== 4'b0001 || btn_any !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_early: level=%b any=%b expected 0001/1", btn_level, btn_any);
    end
    step(1);
    tests_run++;
    if (btn_level !== 4'b0000 || btn_any !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_fall: level=%b any=%b expected 0000/0", btn_level, btn_any);
    end
    step(4);
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 2; j++) begin
        step(1);
        if (btn_level[1] !== 1'b0) bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bounce_quiet: %0d cycles with level[1]=1 expected 0", bad);
    end
    btn_raw[1] = 1'b0;
    step(5);
    tests_run++;
    if (btn_level[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_early: level[1]=%b expected 0", btn_level[1]);
    end
    step(1);
    tests_run++;
    if (btn_level !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bounce_rise: level=%b expected 0010", btn_level);
    end
    btn_raw[1] = 1'b1;
    step(6);
    tests_run++;
    if (btn_level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bounce_release: level=%b expected 0000", btn_level);
    end
    step(4);
  endtask

  task automatic test_glitch();
    int width [3] = '{1, 3, 5};
    int expect_hi [3] = '{0, 0, 5};
    int hi;
    int rises;
    logic prev;
    for (int p = 0; p < 3; p++) begin
      btn_raw[2] = 1'b0;
      step(width[p]);
      btn_raw[2] = 1'b1;
      hi    = 0;
      rises = 0;
      prev  = btn_level[2];
      for (int c = 0; c < 14; c++) begin
        step(1);
        if (btn_level[2] === 1'b1) hi++;
        if (btn_level[2] === 1'b1 && prev === 1'b0) rises++;
        prev = btn_level[2];
      end
      tests_run++;
      if (hi != expect_hi[p] || rises != (expect_hi[p] > 0 ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL glitch_w%0d: high=%0d rises=%0d expected high=%0d", width[p], hi, rises, expect_hi[p]);
      end
    end
  endtask

  task automatic test_parallel();
    btn_raw = 4'b0000;
    step(5);
    tests_run++;
    if (btn_level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL parallel_early: level=%b expected 0000", btn_level);
    end
    step(1);
    tests_run++;
    if (btn_level !== 4'b1111 || btn_any !== 1'b1) begin
      tests_failed++;
      $display("FAIL parallel_rise: level=%b any=%b expected 1111/1", btn_level, btn_any);
    end
    btn_raw = 4'b1111;
    step(6);
    tests_run++;
    if (btn_level !== 4'b0000 || btn_any !== 1'b0) begin
      tests_failed++;
      $display("FAIL parallel_fall: level=%b any=%b expected 0000/0", btn_level, btn_any);
    end
    step(4);
  endtask

  task automatic test_reset_mid();
    btn_raw[3] = 1'b0;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (btn_level !== 4'b0000 || btn_any !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_arm: level=%b any=%b expected 0000/0", btn_level, btn_any);
    end
    step(2);
    rst_n = 1'b1;
    step(5);
    tests_run++;
    if (btn_level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_arm_early: level=%b expected 0000", btn_level);
    end
    step(1);
    tests_run++;
    if (btn_level !== 4'b1000 || btn_any !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_arm_rerise: level=%b any=%b expected 1000/1", btn_level, btn_any);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (btn_level !== 4'b0000 || btn_any !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_pressed_async: level=%b any=%b expected 0000/0", btn_level, btn_any);
    end
    step(1);
    rst_n = 1'b1;
    step(5);
    tests_run++;
    if (btn_level !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_pressed_early: level=%b expected 0000", btn_level);
    end
    step(1);
    tests_run++;
    if (btn_level !== 4'b1000 || btn_any !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pressed_rerise: level=%b any=%b expected 1000/1", btn_level, btn_any);
    end
    btn_raw[3] = 1'b1;
    step(6);
    tests_run++;
    if (btn_level !== 4'b0000 || btn_any !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_final_release: level=%b any=%b expected 0000/0", btn_level, btn_any);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    btn_raw      = 4'b1111;
    step(3);
    rst_n = 1'b1;
    step(2);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_parallel();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
